// File: rtl/info_mapper_pkg.sv
// ---------------------------------------------------------------------------
// info_mapper_pkg
//   Shared helpers for the information mapper / demapper pair.
//   - cw_of(p) : width of a bit count in 0..p
//   - lw_of(p) : width of a buffer fill level in 0..2p-1
//   - popcount : number of set bits in a vector of up to MAX_P bits
// ---------------------------------------------------------------------------
package info_mapper_pkg;

    localparam int MAX_P = 256;

    function automatic int cw_of(input int p);
        return $clog2(p) + 1;
    endfunction

    function automatic int lw_of(input int p);
        return $clog2(p) + 2;
    endfunction

    function automatic int popcount(input logic [MAX_P-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_P; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/info_demapper_bit_gather.sv
// ---------------------------------------------------------------------------
// bit_gather (combinational)
//   Extracts in_data bits at positions where in_mask=1 and compacts them
//   LSB-first in index order.
//   Ports:
//     in_data     [P-1:0]  codeword slice
//     in_mask     [P-1:0]  1 = information position
//     packed_bits [P-1:0]  gathered bits, earliest at [0], upper bits 0
//     count       [CW-1:0] number of gathered bits (0..P)
// ---------------------------------------------------------------------------
module bit_gather
    import info_mapper_pkg::*;
#(
    parameter int P = 8,
    localparam int CW = cw_of(P)
) (
    input  logic [P-1:0]  in_data,
    input  logic [P-1:0]  in_mask,
    output logic [P-1:0]  packed_bits,
    output logic [CW-1:0] count
);

    // Running prefix count: the destination of bit i is the number of set
    // mask bits below i. CW wide so a full mask (count == P) still fits.
    logic [CW-1:0] pos;

    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment so no latch is inferred.
        packed_bits = '0;
        pos         = '0;
        for (int i = 0; i < P; i++) begin
            if (in_mask[i]) begin
                // pos <= i < P here, so the low bits index safely.
                packed_bits[pos[CW-2:0]] = in_data[i];
                pos = pos + 1'b1;
            end
        end
    end

    assign count = CW'(popcount(MAX_P'(in_mask)));

endmodule

// File: rtl/info_demapper.sv
// ---------------------------------------------------------------------------
// info_demapper
//   Inverse of the information mapper: gathers the masked bits of each input
//   beat and repacks them into dense P-bit output words. A packet ends with
//   in_last; its final word may be partial (zero padded) and carries out_last.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     in_valid/in_ready   input handshake (in_ready combinationally follows
//                         out_ready when the buffer is full)
//     in_data, in_mask    codeword slice and information mask
//     in_last             beat is last of packet
//     out_valid/out_ready output handshake
//     out_data            packed info bits, earliest at [0], unused bits 0
//     out_count           valid bits in out_data (P except on final word)
//     out_last            word is last of packet
// ---------------------------------------------------------------------------
module info_demapper
    import info_mapper_pkg::*;
#(
    parameter int MAPPER_PARALLELISM = 8,
    localparam int CW = cw_of(MAPPER_PARALLELISM),
    localparam int LW = lw_of(MAPPER_PARALLELISM)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAPPER_PARALLELISM-1:0] in_data,
    input  logic [MAPPER_PARALLELISM-1:0] in_mask,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAPPER_PARALLELISM-1:0] out_data,
    output logic [CW-1:0]                 out_count,
    output logic                          out_last
);

    localparam int P = MAPPER_PARALLELISM;
    localparam logic [LW-1:0] P_LVL = LW'(P);

    logic [2*P-1:0] bit_buf;
    logic [LW-1:0]  lvl;
    logic           flush;

    logic [P-1:0]   gathered;
    logic [CW-1:0]  gathered_cnt;

    logic           full;
    logic           out_fire;
    logic           in_fire;
    logic [LW-1:0]  lvl_after_out;
    logic [2*P-1:0] buf_after_out;
    logic [2*P-1:0] insert_bits;

    bit_gather #(.P(P)) u_gather (
        .in_data     (in_data),
        .in_mask     (in_mask),
        .packed_bits (gathered),
        .count       (gathered_cnt)
    );

    // Outputs depend only on registered state.
    assign full      = (lvl >= P_LVL);
    assign out_valid = full || flush;
    assign out_count = full ? CW'(P) : lvl[CW-1:0];
    assign out_data  = bit_buf[P-1:0] & ~({P{1'b1}} << out_count);
    assign out_last  = flush && (lvl <= P_LVL);

    assign out_fire  = out_valid && out_ready;
    // Room exists if less than a word is buffered, or a word leaves this cycle.
    assign in_ready  = !rst && !flush && (!full || out_fire);
    assign in_fire   = in_valid && in_ready;

    // Drain first, then append the new bits at the post-drain level.
    assign lvl_after_out = out_fire ? (lvl - LW'(out_count)) : lvl;
    assign buf_after_out = out_fire ? (bit_buf >> P) : bit_buf;
    assign insert_bits   = {{P{1'b0}}, gathered} << lvl_after_out;

    always_ff @(posedge clk) begin
        // NOTE: the bit buffer is cleared on reset, not just the level:
        // insertion ORs new bits in, which relies on every bit above lvl
        // being zero.
        if (rst) begin
            bit_buf <= '0;
            lvl     <= '0;
            flush   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update from the same pre-edge values.
            bit_buf <= in_fire ? (buf_after_out | insert_bits) : buf_after_out;
            lvl     <= in_fire ? (lvl_after_out + LW'(gathered_cnt)) : lvl_after_out;
            // in_fire and flush are mutually exclusive, so order is immaterial.
            if (in_fire && in_last) begin
                flush <= 1'b1;
            end else if (out_fire && out_last) begin
                flush <= 1'b0;
            end
        end
    end

endmodule
